// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - signal bundle between the pong game sequencer and its environment
//
// Purpose: groups the frame tick, player inputs, score pulses and the
//          text/graphics control outputs of pong_game_ctrl.
// Signals:
//   refr_tick   1  one-cycle pulse per frame refresh
//   start       1  level start button
//   point_l     1  one-cycle pulse, left player scored
//   point_r     1  one-cycle pulse, right player scored
//   dig0..dig3  4  left ones/tens, right ones/tens (BCD)
//   ball        2  balls remaining
//   text_en     4  text region enable {score, logo, rule, over}
//   graph_still 1  hold ball and paddles still
//   game_over   1  high while the game is over
// Modports:
//   master - environment side, drives the inputs of the sequencer
//   slave  - sequencer side
interface pong_game_ctrl_if;
  logic       refr_tick;
  logic       start;
  logic       point_l;
  logic       point_r;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [1:0] ball;
  logic [3:0] text_en;
  logic       graph_still;
  logic       game_over;

  modport master (
    output refr_tick, start, point_l, point_r,
    input  dig0, dig1, dig2, dig3, ball, text_en, graph_still, game_over
  );

  modport slave (
    input  refr_tick, start, point_l, point_r,
    output dig0, dig1, dig2, dig3, ball, text_en, graph_still, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: game state, BCD scores, ball count, text/graphics control
//
// Purpose: walks NEWGAME -> PLAY -> NEWBALL/OVER, keeps both BCD scores and
//          the remaining-ball count, and drives the text overlay enables and
//          the graphics freeze.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of pong_game_ctrl_if (inputs refr_tick, start,
//            point_l, point_r; outputs dig0..dig3, ball, text_en,
//            graph_still, game_over)
// Parameters:
//   BALLS        balls per game, 1..3
//   TIMER_TICKS  refr_tick count for the delay in NEWBALL and OVER
//   WIN_SCORE    early-win score (decimal, 0..99)
// Optional feature macro: WIN_SCORE_EN - when defined, a score reaching
//   WIN_SCORE ends the game at once; otherwise WIN_SCORE is unused.
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120,
  parameter int WIN_SCORE   = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;

  localparam int            TW         = $clog2(TIMER_TICKS + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_TICKS);
  localparam logic [1:0]    BALL_INIT  = 2'(BALLS);

  if (BALLS < 1 || BALLS > 3) begin : g_bad_balls
    $error("pong_game_ctrl: BALLS must be 1..3");
  end
  if (WIN_SCORE < 0 || WIN_SCORE > 99) begin : g_bad_win
    $error("pong_game_ctrl: WIN_SCORE must be 0..99");
  end

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)        return v;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t        state;
  logic [TW-1:0] timer;
  logic          start_d;
  logic [7:0]    score_l;
  logic [7:0]    score_r;
  logic [1:0]    ball;
  logic [3:0]    text_en;
  logic          graph_still;
  logic          game_over;

  logic          start_rise;
  logic          timer_done;
  logic          point_any;
  logic          play_point;
  logic          new_game;
  logic          win_hit;
  logic [7:0]    score_l_nxt;
  logic [7:0]    score_r_nxt;
  logic [1:0]    ball_nxt;

  assign start_rise = bus.start & ~start_d;
  assign timer_done = (timer == '0);
  assign point_any  = bus.point_l | bus.point_r;
  assign play_point = (state == PLAY) && point_any;
  assign new_game   = (state == NEWGAME) && start_rise;

  // Score and ball registers reload every cycle from these; only a start
  // in NEWGAME or a point in PLAY changes them.
  always_comb begin
    score_l_nxt = score_l;
    score_r_nxt = score_r;
    ball_nxt    = ball;
    if (new_game) begin
      score_l_nxt = 8'h00;
      score_r_nxt = 8'h00;
      ball_nxt    = BALL_INIT;
    end else if (play_point) begin
      if (bus.point_l) score_l_nxt = bcd_inc(score_l);
      if (bus.point_r) score_r_nxt = bcd_inc(score_r);
      // One ball is consumed per rally even when both sides score together.
      ball_nxt = ball - 2'd1;
    end
  end

`ifdef WIN_SCORE_EN
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  assign win_hit = play_point &&
                   ((bus.point_l && score_l_nxt == WIN_BCD) ||
                    (bus.point_r && score_r_nxt == WIN_BCD));
`else
  assign win_hit = 1'b0;
`endif

  // Outputs are written alongside each transition so they always reflect
  // the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= NEWGAME;
      timer       <= '0;
      start_d     <= 1'b0;
      score_l     <= 8'h00;
      score_r     <= 8'h00;
      ball        <= BALL_INIT;
      text_en     <= 4'b1110;
      graph_still <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      start_d <= bus.start;
      score_l <= score_l_nxt;
      score_r <= score_r_nxt;
      ball    <= ball_nxt;

      if (bus.refr_tick && !timer_done) timer <= timer - TW'(1);

      case (state)
        NEWGAME: begin
          if (start_rise) begin
            state       <= PLAY;
            text_en     <= 4'b1000;
            graph_still <= 1'b0;
            game_over   <= 1'b0;
          end
        end
        PLAY: begin
          if (point_any) begin
            // Load wins over a refr_tick decrement on the same cycle.
            timer       <= TIMER_LOAD;
            graph_still <= 1'b1;
            if (ball == 2'd1 || win_hit) begin
              state     <= OVER;
              text_en   <= 4'b1001;
              game_over <= 1'b1;
            end else begin
              state     <= NEWBALL;
              text_en   <= 4'b1000;
              game_over <= 1'b0;
            end
          end
        end
        NEWBALL: begin
          // A start edge before the delay expires is simply lost.
          if (timer_done && start_rise) begin
            state       <= PLAY;
            text_en     <= 4'b1000;
            graph_still <= 1'b0;
            game_over   <= 1'b0;
          end
        end
        OVER: begin
          if (timer_done) begin
            state       <= NEWGAME;
            text_en     <= 4'b1110;
            graph_still <= 1'b1;
            game_over   <= 1'b0;
          end
        end
        default: begin
          state       <= NEWGAME;
          text_en     <= 4'b1110;
          graph_still <= 1'b1;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dig0        = score_l[3:0];
  assign bus.dig1        = score_l[7:4];
  assign bus.dig2        = score_r[3:0];
  assign bus.dig3        = score_r[7:4];
  assign bus.ball        = ball;
  assign bus.text_en     = text_en;
  assign bus.graph_still = graph_still;
  assign bus.game_over   = game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .BALLS      (3),
    .TIMER_TICKS(120),
    .WIN_SCORE  (11)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.refr_tick = 1'b1;
      cyc();
      bus.refr_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    bus.refr_tick = 1'b0;
    bus.start     = 1'b0;
    bus.point_l   = 1'b0;
    bus.point_r   = 1'b0;
    cyc();
    cyc();

    chk("rst_text_en", {4'd0, bus.text_en}, 8'h0e);
    chk("rst_still",   {7'd0, bus.graph_still}, 8'h01);
    chk("rst_over",    {7'd0, bus.game_over}, 8'h00);
    chk("rst_ball",    {6'd0, bus.ball}, 8'h03);
    chk("rst_digits",  {bus.dig3, bus.dig2}, 8'h00);
    reset_n = 1'b1;
    cyc();

    // Start edge: NEWGAME -> PLAY
    bus.start = 1'b1;
    cyc();
    chk("play_text_en", {4'd0, bus.text_en}, 8'h08);
    chk("play_still",   {7'd0, bus.graph_still}, 8'h00);
    chk("play_ball",    {6'd0, bus.ball}, 8'h03);

    // Start toggling in PLAY is ignored
    bus.start = 1'b0;
    cyc();
    bus.start = 1'b1;
    cyc();
    chk("play_start_ignored", {7'd0, bus.graph_still}, 8'h00);

    // First point, coincident with a refr_tick
    bus.point_l   = 1'b1;
    bus.refr_tick = 1'b1;
    cyc();
    bus.point_l   = 1'b0;
    bus.refr_tick = 1'b0;
    chk("pt1_score_l", {bus.dig1, bus.dig0}, 8'h01);
    chk("pt1_score_r", {bus.dig3, bus.dig2}, 8'h00);
    chk("pt1_ball",    {6'd0, bus.ball}, 8'h02);
    chk("pt1_still",   {7'd0, bus.graph_still}, 8'h01);
    chk("pt1_text_en", {4'd0, bus.text_en}, 8'h08);

    // Points in NEWBALL are ignored
    bus.start   = 1'b0;
    bus.point_r = 1'b1;
    cyc();
    bus.point_r = 1'b0;
    cyc();
    chk("nb_point_ignored", {bus.dig3, bus.dig2}, 8'h00);
    chk("nb_ball_kept",     {6'd0, bus.ball}, 8'h02);

    // Early start edge after 50 ticks is discarded
    ticks(50);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    chk("nb_early_start", {7'd0, bus.graph_still}, 8'h01);

    // Rise at tick 119 and hold high through expiry: no restart
    ticks(69);
    bus.start = 1'b1;
    cyc();
    ticks(1);
    cyc();
    cyc();
    chk("nb_held_start", {7'd0, bus.graph_still}, 8'h01);

    // Fresh edge after expiry resumes play
    bus.start = 1'b0;
    cyc();
    bus.start = 1'b1;
    cyc();
    chk("nb_resume_still", {7'd0, bus.graph_still}, 8'h00);
    chk("nb_resume_text",  {4'd0, bus.text_en}, 8'h08);

    // BCD carry 09 -> 10
    force dut.score_l = 8'h09;
    cyc();
    release dut.score_l;
    bus.point_l = 1'b1;
    cyc();
    bus.point_l = 1'b0;
    chk("carry_score_l", {bus.dig1, bus.dig0}, 8'h10);
    chk("carry_ball",    {6'd0, bus.ball}, 8'h01);

    bus.start = 1'b0;
    ticks(120);
    bus.start = 1'b1;
    cyc();
    chk("resume2_still", {7'd0, bus.graph_still}, 8'h00);

    // Saturation at 99 (ball restored to 2 so the rally does not end the game)
    force dut.score_l = 8'h99;
    force dut.ball    = 2'd2;
    cyc();
    release dut.score_l;
    release dut.ball;
    bus.point_l = 1'b1;
    cyc();
    bus.point_l = 1'b0;
    chk("sat_score_l", {bus.dig1, bus.dig0}, 8'h99);
    chk("sat_ball",    {6'd0, bus.ball}, 8'h01);
    chk("sat_over",    {7'd0, bus.game_over}, 8'h00);

    bus.start = 1'b0;
    ticks(120);
    bus.start = 1'b1;
    cyc();

    // Simultaneous points on the last ball -> OVER
    force dut.score_l = 8'h42;
    force dut.score_r = 8'h07;
    cyc();
    release dut.score_l;
    release dut.score_r;
    bus.point_l = 1'b1;
    bus.point_r = 1'b1;
    cyc();
    bus.point_l = 1'b0;
    bus.point_r = 1'b0;
    chk("both_score_l", {bus.dig1, bus.dig0}, 8'h43);
    chk("both_score_r", {bus.dig3, bus.dig2}, 8'h08);
    chk("both_ball",    {6'd0, bus.ball}, 8'h00);
    chk("over_flag",    {7'd0, bus.game_over}, 8'h01);
    chk("over_text_en", {4'd0, bus.text_en}, 8'h09);
    chk("over_still",   {7'd0, bus.graph_still}, 8'h01);

    bus.point_r = 1'b1;
    cyc();
    bus.point_r = 1'b0;
    chk("over_point_ignored", {bus.dig3, bus.dig2}, 8'h08);

    bus.start = 1'b0;
    ticks(119);
    chk("over_hold", {7'd0, bus.game_over}, 8'h01);
    ticks(1);
    chk("ng_over",      {7'd0, bus.game_over}, 8'h00);
    chk("ng_text_en",   {4'd0, bus.text_en}, 8'h0e);
    chk("ng_kept_l",    {bus.dig1, bus.dig0}, 8'h43);
    chk("ng_kept_r",    {bus.dig3, bus.dig2}, 8'h08);

    // New game clears scores and restores balls
    bus.start = 1'b1;
    cyc();
    chk("ng2_score_l", {bus.dig1, bus.dig0}, 8'h00);
    chk("ng2_score_r", {bus.dig3, bus.dig2}, 8'h00);
    chk("ng2_ball",    {6'd0, bus.ball}, 8'h03);
    chk("ng2_still",   {7'd0, bus.graph_still}, 8'h00);

    // Asynchronous reset mid-PLAY
    bus.point_l = 1'b1;
    cyc();
    bus.point_l = 1'b0;
    ticks(120);
    bus.start = 1'b0;
    cyc();
    bus.start = 1'b1;
    cyc();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_text_en", {4'd0, bus.text_en}, 8'h0e);
    chk("arst_still",   {7'd0, bus.graph_still}, 8'h01);
    chk("arst_score_l", {bus.dig1, bus.dig0}, 8'h00);
    chk("arst_ball",    {6'd0, bus.ball}, 8'h03);
    bus.start = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

`ifdef WIN_SCORE_EN
    bus.start = 1'b1;
    cyc();
    force dut.score_r = 8'h10;
    cyc();
    release dut.score_r;
    bus.point_r = 1'b1;
    cyc();
    bus.point_r = 1'b0;
    chk("win_score_r", {bus.dig3, bus.dig2}, 8'h11);
    chk("win_over",    {7'd0, bus.game_over}, 8'h01);
    chk("win_ball",    {6'd0, bus.ball}, 8'h02);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
